// File: rtl/multicycle_ctrl.sv
// Multicycle controller: six-state FSM driving the datapath of a
// single-bus MIPS-style core, with a retired-instruction counter.
module multicycle_ctrl #(
  parameter logic [5:0] OP_HALT = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [5:0]  Op_code,
  input  logic        zero,
  output logic [2:0]  state,
  output logic        PCWre,
  output logic        IRWre,
  output logic        RegWre,
  output logic        RegDst,
  output logic        ExtSel,
  output logic        ALUSrcA,
  output logic        ALUSrcB,
  output logic        DBDataSrc,
  output logic        nRD,
  output logic        nWR,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [5:0]  op_q;
  logic [31:0] cnt_q;

  logic is_add, is_sub, is_addi, is_and;
  logic is_or, is_ori, is_sll, is_slt;
  logic is_sw, is_lw, is_beq, is_bne;
  logic is_j, is_halt, is_legal;
  logic is_r, is_br, is_mem;

  assign is_add  = op_q == 6'b000000;
  assign is_sub  = op_q == 6'b000001;
  assign is_addi = op_q == 6'b000010;
  assign is_and  = op_q == 6'b010000;
  assign is_or   = op_q == 6'b010001;
  assign is_ori  = op_q == 6'b010010;
  assign is_sll  = op_q == 6'b011000;
  assign is_slt  = op_q == 6'b100110;
  assign is_sw   = op_q == 6'b110000;
  assign is_lw   = op_q == 6'b110001;
  assign is_beq  = op_q == 6'b110100;
  assign is_bne  = op_q == 6'b110101;
  assign is_j    = op_q == 6'b111000;
  assign is_halt = op_q == OP_HALT;

  assign is_r   = is_add | is_sub | is_and
                | is_or | is_sll | is_slt;
  assign is_br  = is_beq | is_bne;
  assign is_mem = is_lw | is_sw;

  assign is_legal = is_r | is_addi | is_ori
                  | is_mem | is_br | is_j
                  | is_halt;

  assign state   = state_q;
  assign retired = cnt_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      op_q    <= 6'b000000;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IF) op_q <= Op_code;
      if (PCWre) cnt_q <= cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    PCSrc     = 2'b00;
    nRD       = 1'b1;
    nWR       = 1'b1;
    RegDst    = is_r && (state_q == S_WB);
    ExtSel    = !is_ori;
    ALUSrcA   = is_sll;
    ALUSrcB   = is_addi | is_ori | is_mem;
    DBDataSrc = is_lw;

    ALUOp = 3'b000;
    unique case (1'b1)
      is_sub, is_beq, is_bne: ALUOp = 3'b001;
      is_and:                 ALUOp = 3'b010;
      is_or, is_ori:          ALUOp = 3'b011;
      is_sll:                 ALUOp = 3'b100;
      is_slt:                 ALUOp = 3'b101;
      default:                ALUOp = 3'b000;
    endcase

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        // j and unknown opcodes retire straight from decode
        if (is_j || !is_legal) begin
          PCWre   = 1'b1;
          PCSrc   = is_j ? 2'b10 : 2'b00;
          state_d = S_IF;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (is_br) begin
          PCWre   = 1'b1;
          PCSrc   = ((is_beq && zero) || (is_bne && !zero))
                  ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        nRD = !is_lw;
        nWR = !is_sw;
        if (is_sw) begin
          PCWre   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        PCWre   = 1'b1;
        RegWre  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_multicycle_ctrl;

  logic        CLK;
  logic        Reset;
  logic [5:0]  Op_code;
  logic        zero;
  logic [2:0]  state;
  logic        PCWre, IRWre, RegWre, RegDst, ExtSel;
  logic        ALUSrcA, ALUSrcB, DBDataSrc, nRD, nWR;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp;
  logic [31:0] retired;

  int n_chk  = 0;
  int n_pass = 0;

  multicycle_ctrl dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Op_code   (Op_code),
    .zero      (zero),
    .state     (state),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .ExtSel    (ExtSel),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .DBDataSrc (DBDataSrc),
    .nRD       (nRD),
    .nWR       (nWR),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .retired   (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b0;
    #1;
    check("rst_state", state, 3'b000);
    check("rst_ret", retired, 32'd0);
    step;
    Reset = 1'b1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [2:0] alu;
    logic       sa;
    logic       sb;
    logic       ext;
    logic       dst;
  } vec_t;

  vec_t tbl [7] = '{
    '{6'b000001, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'b000010, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
    '{6'b010000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'b010001, 3'b011, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'b010010, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0},
    '{6'b011000, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1},
    '{6'b100110, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1}
  };

  initial begin
    Reset   = 1'b0;
    Op_code = 6'b000000;
    zero    = 1'b0;
    step;
    step;
    check("rst_state", state, 3'b000);
    check("rst_ret", retired, 32'd0);
    check("rst_pcwre", PCWre, 1'b0);
    check("rst_nwr", nWR, 1'b1);
    check("rst_irwre", IRWre, 1'b1);
    Reset = 1'b1;

    // add, with Op_code changed after IF to prove latching
    Op_code = 6'b000000;
    step;
    check("add_id", state, 3'b001);
    check("add_id_irwre", IRWre, 1'b0);
    Op_code = 6'b110000;
    step;
    check("add_exe", state, 3'b010);
    check("add_exe_dst", RegDst, 1'b0);
    check("add_exe_rw", RegWre, 1'b0);
    check("add_exe_pcw", PCWre, 1'b0);
    check("add_alu", ALUOp, 3'b000);
    step;
    check("add_wb", state, 3'b100);
    check("add_wb_rw", RegWre, 1'b1);
    check("add_wb_dst", RegDst, 1'b1);
    check("add_wb_pcw", PCWre, 1'b1);
    step;
    check("add_if", state, 3'b000);
    check("add_ret", retired, 32'd1);

    foreach (tbl[i]) begin
      Op_code = tbl[i].op;
      step;
      Op_code = ~tbl[i].op;
      step;
      check($sformatf("t%0d_exe", i), state, 3'b010);
      check($sformatf("t%0d_alu", i), ALUOp, tbl[i].alu);
      check($sformatf("t%0d_sa", i), ALUSrcA, tbl[i].sa);
      check($sformatf("t%0d_sb", i), ALUSrcB, tbl[i].sb);
      check($sformatf("t%0d_ext", i), ExtSel, tbl[i].ext);
      step;
      check($sformatf("t%0d_wb", i), state, 3'b100);
      check($sformatf("t%0d_rw", i), RegWre, 1'b1);
      check($sformatf("t%0d_dst", i), RegDst, tbl[i].dst);
      step;
    end
    check("tbl_ret", retired, 32'd8);

    // lw then sw
    do_reset;
    Op_code = 6'b110001;
    step;
    step;
    check("lw_exe_sb", ALUSrcB, 1'b1);
    step;
    check("lw_mem", state, 3'b011);
    check("lw_nrd", nRD, 1'b0);
    check("lw_nwr", nWR, 1'b1);
    check("lw_dbs", DBDataSrc, 1'b1);
    check("lw_mem_pcw", PCWre, 1'b0);
    step;
    check("lw_wb", state, 3'b100);
    check("lw_wb_pcw", PCWre, 1'b1);
    check("lw_wb_dst", RegDst, 1'b0);
    step;
    check("lw_if", state, 3'b000);
    Op_code = 6'b110000;
    step;
    step;
    step;
    check("sw_mem", state, 3'b011);
    check("sw_nwr", nWR, 1'b0);
    check("sw_nrd", nRD, 1'b1);
    check("sw_pcw", PCWre, 1'b1);
    check("sw_rw", RegWre, 1'b0);
    step;
    check("sw_if", state, 3'b000);
    check("sw_if_nwr", nWR, 1'b1);
    check("lwsw_ret", retired, 32'd2);

    // beq taken, beq not taken, bne taken
    do_reset;
    Op_code = 6'b110100;
    zero = 1'b1;
    step;
    step;
    check("beq1_exe", state, 3'b010);
    check("beq1_src", PCSrc, 2'b01);
    check("beq1_pcw", PCWre, 1'b1);
    check("beq1_alu", ALUOp, 3'b001);
    check("beq1_rw", RegWre, 1'b0);
    step;
    check("beq1_if", state, 3'b000);
    zero = 1'b0;
    step;
    step;
    check("beq0_src", PCSrc, 2'b00);
    check("beq0_pcw", PCWre, 1'b1);
    check("beq0_rw", RegWre, 1'b0);
    step;
    check("beq0_if", state, 3'b000);
    Op_code = 6'b110101;
    step;
    step;
    check("bne0_src", PCSrc, 2'b01);
    step;
    check("br_ret", retired, 32'd3);

    // j then an unknown opcode
    do_reset;
    Op_code = 6'b111000;
    step;
    check("j_id", state, 3'b001);
    check("j_src", PCSrc, 2'b10);
    check("j_pcw", PCWre, 1'b1);
    step;
    check("j_if", state, 3'b000);
    Op_code = 6'b101010;
    step;
    check("ill_src", PCSrc, 2'b00);
    check("ill_pcw", PCWre, 1'b1);
    check("ill_rw", RegWre, 1'b0);
    check("ill_nwr", nWR, 1'b1);
    step;
    check("ill_if", state, 3'b000);
    check("jill_ret", retired, 32'd2);

    // reset in the middle of sw, before its memory write
    do_reset;
    Op_code = 6'b110000;
    step;
    step;
    #2;
    Reset = 1'b0;
    #1;
    check("abort_state", state, 3'b000);
    check("abort_nwr", nWR, 1'b1);
    check("abort_pcw", PCWre, 1'b0);
    step;
    check("abort_nwr2", nWR, 1'b1);
    check("abort_ret", retired, 32'd0);
    Reset = 1'b1;

    // add, then halt for 100 cycles, then async reset
    Op_code = 6'b000000;
    repeat (4) step;
    check("pre_halt_ret", retired, 32'd1);
    Op_code = 6'b111111;
    step;
    check("halt_id", state, 3'b001);
    Op_code = 6'b000000;
    step;
    check("halt_st", state, 3'b101);
    check("halt_pcw", PCWre, 1'b0);
    repeat (100) begin
      step;
      check("halt_hold", state, 3'b101);
      check("halt_pcw_h", PCWre, 1'b0);
    end
    check("halt_ret", retired, 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("halt_rst_st", state, 3'b000);
    check("halt_rst_ret", retired, 32'd0);
    step;
    Reset = 1'b1;

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    check("wrap_pre", retired, 32'hFFFF_FFFF);
    Op_code = 6'b000000;
    repeat (3) step;
    check("wrap_wb_pcw", PCWre, 1'b1);
    step;
    check("wrap_ret", retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
